// File: rtl/clk_divider_multi.sv
// -----------------------------------------------------------------------------
// clk_divider_multi
//
// N-channel programmable clock divider / tick generator. Every channel counts
// enabled CCLK cycles up to its active scale S and then produces a terminal
// event every S+1 enabled cycles. In toggle mode the channel output clock
// flips at each terminal (period 2*(S+1), 50% duty); in pulse mode only the
// one-cycle tick is produced and the clock output is held low.
//
// The runtime scale and mode inputs are copied into per-channel shadow
// registers only while the channel is idle, on restart, or at a terminal
// count. A period that has already started therefore always completes with
// the settings it started with, so the outputs cannot glitch.
//
// Ports
//   CCLK     in   1            system clock, rising edge
//   RST_N    in   1            asynchronous active-low reset
//   en       in   N_CH         per-channel enable (level)
//   restart  in   N_CH         per-channel synchronous restart (pulse)
//   mode     in   N_CH         per-channel mode: 0 = toggle clock, 1 = tick only
//   scale    in   N_CH*WIDTH   flat scale vector, channel i at [i*WIDTH +: WIDTH]
//   clk_out  out  N_CH         divided clock, registered
//   tick     out  N_CH         one-cycle terminal-count pulse, registered
// -----------------------------------------------------------------------------
module clk_divider_multi #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32
) (
    input  logic                    CCLK,
    input  logic                    RST_N,
    input  logic [N_CH-1:0]         en,
    input  logic [N_CH-1:0]         restart,
    input  logic [N_CH-1:0]         mode,
    input  logic [N_CH*WIDTH-1:0]   scale,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Per-channel state
    logic [N_CH-1:0][WIDTH-1:0] cnt_q,       cnt_d;
    logic [N_CH-1:0][WIDTH-1:0] act_scale_q, act_scale_d;
    logic [N_CH-1:0]            act_mode_q,  act_mode_d;
    logic [N_CH-1:0]            clk_out_q,   clk_out_d;
    logic [N_CH-1:0]            tick_q,      tick_d;

    // Next-state logic for every channel; channels share nothing.
    always_comb begin
        cnt_d       = cnt_q;
        act_scale_d = act_scale_q;
        act_mode_d  = act_mode_q;
        clk_out_d   = clk_out_q;
        tick_d      = tick_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (restart[ch] || !en[ch]) begin
                // Restart and idle behave identically: clear the period and
                // let the shadows follow the inputs so the first period after
                // enable/restart uses the current settings.
                cnt_d[ch]       = CNT_ZERO;
                clk_out_d[ch]   = 1'b0;
                tick_d[ch]      = 1'b0;
                act_scale_d[ch] = scale[ch*WIDTH +: WIDTH];
                act_mode_d[ch]  = mode[ch];
            end else if (cnt_q[ch] >= act_scale_q[ch]) begin
                // Terminal count. ">=" rather than "==" so the counter can
                // never run past the shadow scale and wrap.
                cnt_d[ch]       = CNT_ZERO;
                tick_d[ch]      = 1'b1;
                if (act_mode_q[ch]) begin
                    clk_out_d[ch] = 1'b0;
                end else begin
                    clk_out_d[ch] = ~clk_out_q[ch];
                end
                // Period boundary: the only point where a running channel
                // picks up new settings.
                act_scale_d[ch] = scale[ch*WIDTH +: WIDTH];
                act_mode_d[ch]  = mode[ch];
            end else begin
                cnt_d[ch]       = cnt_q[ch] + CNT_ONE;
                tick_d[ch]      = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q       <= '0;
            act_scale_q <= '0;
            act_mode_q  <= '0;
            clk_out_q   <= '0;
            tick_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            act_scale_q <= act_scale_d;
            act_mode_q  <= act_mode_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_divider_multi
//
// Directed bench for clk_divider_multi (N_CH = 4, WIDTH = 8). A table of
// per-edge vectors {en, restart, mode, scale, expected clk_out, expected tick}
// covers the single-channel behaviours; hand-written sequences cover the
// multi-channel run, the maximum scale and asynchronous reset mid-count.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_clk_divider_multi;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;

    logic                  CCLK;
    logic                  RST_N;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       restart;
    logic [N_CH-1:0]       mode;
    logic [N_CH*WIDTH-1:0] scale;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  rs;
        logic [3:0]  md;
        logic [31:0] sc;
        logic [3:0]  ec;
        logic [3:0]  et;
    } vec_t;

    vec_t tbl[$];

    clk_divider_multi #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) dut (
        .CCLK    (CCLK),
        .RST_N   (RST_N),
        .en      (en),
        .restart (restart),
        .mode    (mode),
        .scale   (scale),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial begin
        CCLK = 1'b0;
        forever #5 CCLK = ~CCLK;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [3:0] e, input logic [3:0] r,
                                input logic [3:0] m, input logic [31:0] s,
                                input logic [3:0] c, input logic [3:0] t);
        vec_t v;
        v.en = e; v.rs = r; v.md = m; v.sc = s; v.ec = c; v.et = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] ec, input logic [3:0] et);
        n_checks++;
        if ({clk_out, tick} !== {ec, et}) begin
            n_fail++;
            $display("FAIL %s: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                     name, clk_out, tick, ec, et);
        end
    endtask

    task automatic step();
        @(posedge CCLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] e, input logic [3:0] r,
                         input logic [3:0] m, input logic [31:0] s);
        en = e; restart = r; mode = m; scale = s;
    endtask

    task automatic build_table();
        // ch0 toggle, S = 3: rises at edge 4, falls at edge 8
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0001));
        // ch1 pulse, S = 2: tick at edges 3, 6, 9; clk_out stays 0
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000200, 4'b0000,
                             ((k % 3) == 0) ? 4'b0010 : 4'b0000));
        // ch1 pulse, S = 0: tick held high
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0010, 32'h00000000, 4'b0000, 4'b0000));
        for (int k = 1; k <= 3; k++)
            tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000000, 4'b0000, 4'b0010));
        // ch2 toggle, S = 0: CCLK/2 with tick held high
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 4'b0100));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0100));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 32'h00000000, 4'b0100, 4'b0100));
        // ch0 S = 3, S = 1 written after edge 2: terminals at 4, 6, 8
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0001, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0001, 4'b0001));
        // ch0 S = 1, switch to pulse while clk_out high: held until boundary, then 0
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0001, 32'h00000001, 4'b0001, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0001, 32'h00000001, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0001, 32'h00000001, 4'b0000, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0001, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0001, 32'h00000001, 4'b0000, 4'b0001));
        // ch0 S = 3 toggle, en dropped at cnt = 2, re-enabled: toggle after 4 edges
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000003, 4'b0001, 4'b0001));
        // ch1 pulse S = 2, restart on the terminal edge: no tick, count restarts
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0010, 32'h00000200, 4'b0000, 4'b0010));
        // ch0 toggle S = 1, restart while clk_out high clears it
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0001, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0000, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 32'h00000001, 4'b0001, 4'b0001));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000));
    endtask

    initial begin
        int s_tab[4];
        logic [3:0] ec;
        logic [3:0] et;
        string nm;

        // Reset held with all channels enabled at S = 3
        RST_N = 1'b0;
        drive(4'b1111, 4'b0000, 4'b0000, 32'h03030303);
        #1;
        check("reset_async_initial", 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) step();
        check("reset_hold", 4'b0000, 4'b0000);
        drive(4'b0000, 4'b0000, 4'b0000, 32'h00000000);
        RST_N = 1'b1;
        step();
        check("after_reset_idle", 4'b0000, 4'b0000);

        // Table-driven single-channel vectors
        build_table();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].rs, tbl[i].md, tbl[i].sc);
            step();
            nm = $sformatf("vec_%0d", i);
            check(nm, tbl[i].ec, tbl[i].et);
        end

        // All four channels in toggle mode, S = {0,1,4,9}: periods 2, 4, 10, 20
        s_tab[0] = 0; s_tab[1] = 1; s_tab[2] = 4; s_tab[3] = 9;
        drive(4'b0000, 4'b0000, 4'b0000, 32'h09040100);
        step();
        for (int k = 1; k <= 40; k++) begin
            drive(4'b1111, 4'b0000, 4'b0000, 32'h09040100);
            step();
            for (int c = 0; c < 4; c++) begin
                ec[c] = ((k / (s_tab[c] + 1)) % 2) == 1;
                et[c] = (k % (s_tab[c] + 1)) == 0;
            end
            nm = $sformatf("multi_edge_%0d", k);
            check(nm, ec, et);
        end

        // Maximum scale on ch3: first terminal on the 256th enabled edge
        drive(4'b0000, 4'b0000, 4'b0000, 32'hFF000000);
        step();
        for (int k = 1; k <= 256; k++) begin
            drive(4'b1000, 4'b0000, 4'b0000, 32'hFF000000);
            step();
            nm = $sformatf("max_scale_edge_%0d", k);
            if (k == 256) check(nm, 4'b1000, 4'b1000);
            else          check(nm, 4'b0000, 4'b0000);
        end

        // Asynchronous reset mid-count, then restart with the cleared shadows
        drive(4'b0000, 4'b0000, 4'b0000, 32'h00000003);
        step();
        for (int k = 1; k <= 6; k++) begin
            drive(4'b0001, 4'b0000, 4'b0000, 32'h00000003);
            step();
        end
        check("pre_reset_high", 4'b0001, 4'b0000);
        #2;
        RST_N = 1'b0;
        #1;
        check("reset_mid_count", 4'b0000, 4'b0000);
        #2;
        RST_N = 1'b1;
        // act_scale is 0 after reset, so the first enabled edge is terminal
        step();
        check("post_reset_edge1", 4'b0001, 4'b0001);
        step();
        check("post_reset_edge2", 4'b0001, 4'b0000);
        step();
        check("post_reset_edge3", 4'b0001, 4'b0000);
        step();
        check("post_reset_edge4", 4'b0001, 4'b0000);
        step();
        check("post_reset_edge5", 4'b0000, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
Parametrised N-channel programmable clock divider and tick generator. It is the successor to the single-channel divider. Each channel has its own runtime scale, enable, synchronous restart and output mode (50% toggle clock or single-cycle tick). Scale and mode changes take effect only at a period boundary, so outputs never glitch. The block feeds the elevator controller's timing domains: door timer, floor-travel timer and display refresh.

Parameters:
N_CH, 4, number of independent divider channels (1..16).
WIDTH, 32, width of each channel's scale value and counter.

Ports:
CCLK  input  1  system clock; all logic is on its rising edge.
RST_N  input  1  asynchronous active-low reset.
en  input  N_CH  per-channel enable; level-sensitive.
restart  input  N_CH  per-channel synchronous restart; single-cycle pulse.
mode  input  N_CH  per-channel mode: 0 = toggle (clock out), 1 = pulse (tick only).
scale  input  N_CH*WIDTH  flat per-channel scale S; channel i uses bits [i*WIDTH +: WIDTH].
clk_out  output  N_CH  divided clock; registered.
tick  output  N_CH  one-CCLK-cycle pulse at each terminal count; registered.

Behaviour:
- Reset (RST_N low, asynchronous, any time):
  - cnt = 0, act_scale = 0, act_mode = 0, clk_out = 0, tick = 0 for all channels.
  - Takes effect immediately, without waiting for CCLK.
- Per-channel state:
  - cnt[WIDTH]
  - act_scale[WIDTH] (shadow of scale)
  - act_mode (shadow of mode)
- Per-channel priority each rising edge, highest first:
  1. restart = 1: cnt <= 0, clk_out <= 0, tick <= 0, act_scale <= scale, act_mode <= mode. Restart wins over a simultaneous terminal count and applies even when en = 0.
  2. en = 0: cnt <= 0, clk_out <= 0, tick <= 0, act_scale <= scale, act_mode <= mode. The shadows track the inputs while the channel is idle.
  3. en = 1 and cnt >= act_scale (terminal):
     - cnt <= 0, tick <= 1.
     - If act_mode = 0: clk_out <= ~clk_out. If act_mode = 1: clk_out <= 0.
     - act_scale <= scale, act_mode <= mode. This is the boundary update.
  4. en = 1, otherwise: cnt <= cnt + 1, tick <= 0.
- Timing:
  - Terminal occurs every S+1 enabled cycles.
  - Toggle mode: clk_out period = 2*(S+1) CCLK cycles, 50% duty.
  - Pulse mode: tick period = S+1 cycles.
- First event:
  - The first terminal occurs on the (S+1)-th rising edge with en = 1 after enable or restart.
  - tick and the clk_out transition are visible in the same cycle.
- S = 0:
  - Toggle mode: clk_out toggles every cycle (CCLK/2), and tick is held continuously high.
  - Pulse mode: tick is held continuously high.
- Scale change mid-period:
  - Ignored until the current terminal.
  - The new value governs the next period.
  - The ">=" compare keeps behaviour safe even if act_scale were to shrink below cnt.
- Mode change mid-period: same as scale; on switching to pulse, clk_out is forced to 0 at the boundary.
- Counter never exceeds act_scale, so there is no wrap. S = 2^WIDTH-1 is legal and gives the maximum period.
- Channels are fully independent; there is no shared state.
- Combinational paths from inputs to outputs are forbidden.

Test Plan:
- Reset: hold RST_N = 0 with en = all ones, S = 3 -> clk_out = 0, tick = 0. Assert RST_N = 0 mid-count -> outputs clear before the next CCLK edge.
- Toggle mode, ch0, S = 3, en rises at edge 0 -> clk_out rises at edge 4, falls at edge 8 (period 8), tick high in cycles 4 and 8 only.
- Pulse mode, ch1, S = 2 -> tick high every 3rd cycle (edges 3, 6, 9), clk_out stays 0. With S = 0 -> tick constantly 1.
- Scale change mid-period: ch0 at S = 3, write S = 1 at edge 2 -> next edge at 4 (old S), then 6, 8 (new S).
- Enable/restart: drop en at cnt = 2 -> clk_out = 0, cnt = 0 next edge; re-enable -> first toggle at S+1 edges. Pulse restart on a terminal edge -> no tick, no toggle, count restarts.
- Multi-channel: N_CH = 4, S = {0, 1, 4, 9} all in toggle mode -> clk_out periods 2, 4, 10, 20 observed simultaneously with no cross-channel interaction.
